// File: rtl/dmem_access_if.sv
// Bundle of request/response signals between the MEM-stage requesters and the
// data-memory access controller.
interface dmem_access_if;
  logic        pipe_req;
  logic [31:0] pipe_addr;
  logic        fill_req;
  logic [31:0] fill_addr;
  logic        mem_hit;
  logic        mem_addr_sel;
  logic [31:0] mem_addr;
  logic        mem_en;
  logic        pipe_done;
  logic        pipe_stall;
  logic        fill_gnt;

  modport master (
    output pipe_req, pipe_addr, fill_req, fill_addr, mem_hit,
    input  mem_addr_sel, mem_addr, mem_en, pipe_done, pipe_stall, fill_gnt
  );

  modport slave (
    input  pipe_req, pipe_addr, fill_req, fill_addr, mem_hit,
    output mem_addr_sel, mem_addr, mem_en, pipe_done, pipe_stall, fill_gnt
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Arbitrates the MEM-stage data-memory port between the pipeline and the fill engine,
// with miss wait-and-retry and fill starvation bound. DMEM_MISS_PERF_EN adds a miss counter.
module dmem_access_ctrl #(
  parameter int unsigned MISS_LAT   = 4,
  parameter int unsigned STARVE_MAX = 3,
  parameter int unsigned CNT_W      = 3
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  dmem_access_if.slave dmem_bus
`ifdef DMEM_MISS_PERF_EN
  ,
  input  logic         i_miss_count_clr,
  output logic [15:0]  o_miss_count
`endif
);

  typedef enum logic [1:0] {StArb, StGntP, StGntF, StMiss} state_e;

  localparam logic [CNT_W-1:0] MissInit  = CNT_W'(MISS_LAT - 1);
  localparam logic [CNT_W-1:0] StarveLim = CNT_W'(STARVE_MAX);

  state_e            r_state, w_state_d;
  logic [CNT_W-1:0]  r_miss_cnt, w_miss_cnt_d;
  logic [CNT_W-1:0]  r_starve_cnt, w_starve_cnt_d;
  logic              w_gnt_p, w_gnt_f, w_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StArb;
      r_miss_cnt   <= '0;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_d;
      r_miss_cnt   <= w_miss_cnt_d;
      r_starve_cnt <= w_starve_cnt_d;
    end
  end

  always_comb begin
    w_state_d      = r_state;
    w_miss_cnt_d   = r_miss_cnt;
    w_starve_cnt_d = r_starve_cnt;
    unique case (r_state)
      StArb: begin
        if (dmem_bus.pipe_req && dmem_bus.fill_req) begin
          // Pipeline wins until the fill has been passed over STARVE_MAX times.
          if (r_starve_cnt < StarveLim) begin
            w_state_d      = StGntP;
            w_starve_cnt_d = r_starve_cnt + CNT_W'(1);
          end else begin
            w_state_d = StGntF;
          end
        end else if (dmem_bus.pipe_req) begin
          w_state_d = StGntP;
        end else if (dmem_bus.fill_req) begin
          w_state_d = StGntF;
        end
      end
      StGntP: begin
        if (!dmem_bus.pipe_req || dmem_bus.mem_hit) begin
          w_state_d = StArb;
        end else begin
          w_state_d    = StMiss;
          w_miss_cnt_d = MissInit;
        end
      end
      StMiss: begin
        if (!dmem_bus.pipe_req) begin
          w_state_d = StArb;
        end else if (r_miss_cnt == '0) begin
          w_state_d = StGntP;
        end else begin
          w_miss_cnt_d = r_miss_cnt - CNT_W'(1);
        end
      end
      StGntF: begin
        w_starve_cnt_d = '0;
        w_state_d      = (dmem_bus.fill_req && !dmem_bus.pipe_req) ? StGntF : StArb;
      end
      default: w_state_d = StArb;
    endcase
  end

  assign w_gnt_p = (r_state == StGntP);
  assign w_gnt_f = (r_state == StGntF);
  assign w_done  = w_gnt_p && dmem_bus.pipe_req && dmem_bus.mem_hit;

  assign dmem_bus.mem_addr_sel = w_gnt_f;
  assign dmem_bus.mem_addr     = w_gnt_f ? dmem_bus.fill_addr : dmem_bus.pipe_addr;
  assign dmem_bus.mem_en       = w_gnt_p || w_gnt_f;
  assign dmem_bus.pipe_done    = w_done;
  assign dmem_bus.pipe_stall   = dmem_bus.pipe_req && !w_done;
  assign dmem_bus.fill_gnt     = w_gnt_f;

`ifdef DMEM_MISS_PERF_EN
  logic [15:0] r_miss_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_miss_count <= '0;
    end else if (i_miss_count_clr) begin
      r_miss_count <= '0;
    end else if (w_gnt_p && !dmem_bus.mem_hit && (r_miss_count != 16'hFFFF)) begin
      r_miss_count <= r_miss_count + 16'd1;
    end
  end

  assign o_miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: directed vector table, async-reset
// sequences, then random traffic against a behavioural model.
module tb_dmem_access_ctrl;
  localparam int MissLat   = 4;
  localparam int StarveMax = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dmem_access_if bus ();

`ifdef DMEM_MISS_PERF_EN
  logic        miss_clr;
  logic [15:0] miss_count;
`endif

  dmem_access_ctrl #(
    .MISS_LAT  (MissLat),
    .STARVE_MAX(StarveMax),
    .CNT_W     (3)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .dmem_bus        (bus)
`ifdef DMEM_MISS_PERF_EN
    ,
    .i_miss_count_clr(miss_clr),
    .o_miss_count    (miss_count)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  typedef struct {
    logic        pr, fr, hit;
    logic [31:0] pa, fa;
    logic        sel, en;
    logic [31:0] addr;
    logic        done, stall, gnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic pr, logic fr, logic hit, logic [31:0] pa, logic [31:0] fa,
                             logic sel, logic en, logic [31:0] addr, logic done, logic stall,
                             logic gnt);
    vec_t r;
    r.pr = pr; r.fr = fr; r.hit = hit; r.pa = pa; r.fa = fa;
    r.sel = sel; r.en = en; r.addr = addr; r.done = done; r.stall = stall; r.gnt = gnt;
    return r;
  endfunction

  task automatic drive(input logic pr, input logic fr, input logic hit,
                       input logic [31:0] pa, input logic [31:0] fa);
    bus.pipe_req = pr; bus.fill_req = fr; bus.mem_hit = hit;
    bus.pipe_addr = pa; bus.fill_addr = fa;
  endtask

  // Behavioural model: who holds the port this cycle, and remaining miss-wait cycles.
  localparam int OwnNone = 0, OwnPipe = 1, OwnFill = 2;
  int m_owner, m_wait, m_starve, m_misses;

  task automatic model_reset();
    m_owner = OwnNone; m_wait = 0; m_starve = 0; m_misses = 0;
  endtask

  task automatic model_step(input logic pr, input logic fr, input logic hit, input logic clr);
    if (clr) m_misses = 0;
    else if (m_owner == OwnPipe && !hit && m_misses < 65535) m_misses++;
    if (m_owner == OwnPipe) begin
      m_owner = OwnNone;
      if (pr && !hit) m_wait = MissLat;
    end else if (m_owner == OwnFill) begin
      m_starve = 0;
      m_owner  = (fr && !pr) ? OwnFill : OwnNone;
    end else if (m_wait > 0) begin
      if (!pr) m_wait = 0;
      else begin
        m_wait--;
        if (m_wait == 0) m_owner = OwnPipe;
      end
    end else if (pr && fr) begin
      if (m_starve < StarveMax) begin
        m_owner = OwnPipe;
        m_starve++;
      end else m_owner = OwnFill;
    end else if (pr) m_owner = OwnPipe;
    else if (fr) m_owner = OwnFill;
  endtask

  initial begin
    logic        pr, fr, hit, clr, prev_done, e_done;
    logic [31:0] pa, fa;

    rst_n = 1'b0;
    drive(0, 0, 0, 32'h40, 32'h0);
`ifdef DMEM_MISS_PERF_EN
    miss_clr = 1'b0;
`endif
    #2;
    check("rst.en", bus.mem_en, 0);
    check("rst.sel", bus.mem_addr_sel, 0);
    check("rst.done", bus.pipe_done, 0);
    check("rst.gnt", bus.fill_gnt, 0);
    check("rst.stall", bus.pipe_stall, 0);
`ifdef DMEM_MISS_PERF_EN
    check("rst.miss_count", miss_count, 0);
`endif
    @(negedge clk) rst_n = 1'b1;

    // Hit, miss/retry, fill back-to-back, starvation, flush during miss.
    vecs.push_back(v(1, 0, 0, 'h40, 0, 0, 0, 'h40, 0, 1, 0));
    vecs.push_back(v(1, 0, 1, 'h40, 0, 0, 1, 'h40, 1, 0, 0));
    vecs.push_back(v(1, 0, 0, 'h40, 0, 0, 0, 'h40, 0, 1, 0));
    vecs.push_back(v(1, 0, 0, 'h40, 0, 0, 1, 'h40, 0, 1, 0));
    for (int i = 0; i < MissLat; i++) vecs.push_back(v(1, 0, 0, 'h40, 0, 0, 0, 'h40, 0, 1, 0));
    vecs.push_back(v(1, 0, 1, 'h40, 0, 0, 1, 'h40, 1, 0, 0));
    vecs.push_back(v(0, 1, 0, 'h40, 'h100, 0, 0, 'h40, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, 'h40, 'h100, 1, 1, 'h100, 0, 0, 1));
    vecs.push_back(v(0, 1, 0, 'h40, 'h104, 1, 1, 'h104, 0, 0, 1));
    vecs.push_back(v(0, 0, 0, 'h40, 'h108, 1, 1, 'h108, 0, 0, 1));
    vecs.push_back(v(0, 0, 0, 'h40, 'h108, 0, 0, 'h40, 0, 0, 0));
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < StarveMax; i++) begin
        vecs.push_back(v(1, 1, 1, 'h80, 'h200, 0, 0, 'h80, 0, 1, 0));
        vecs.push_back(v(1, 1, 1, 'h80, 'h200, 0, 1, 'h80, 1, 0, 0));
      end
      vecs.push_back(v(1, 1, 1, 'h80, 'h200, 0, 0, 'h80, 0, 1, 0));
      vecs.push_back(v(1, 1, 1, 'h80, 'h200, 1, 1, 'h200, 0, 1, 1));
    end
    vecs.push_back(v(0, 0, 0, 'h40, 0, 0, 0, 'h40, 0, 0, 0));
    vecs.push_back(v(1, 0, 0, 'h40, 0, 0, 0, 'h40, 0, 1, 0));
    vecs.push_back(v(1, 0, 0, 'h40, 0, 0, 1, 'h40, 0, 1, 0));
    vecs.push_back(v(0, 0, 0, 'h40, 0, 0, 0, 'h40, 0, 0, 0));
    vecs.push_back(v(0, 0, 1, 'h40, 0, 0, 0, 'h40, 0, 0, 0));
    vecs.push_back(v(0, 0, 1, 'h40, 0, 0, 0, 'h40, 0, 0, 0));

    @(posedge clk) #1;
    foreach (vecs[i]) begin
      drive(vecs[i].pr, vecs[i].fr, vecs[i].hit, vecs[i].pa, vecs[i].fa);
      @(negedge clk);
      check($sformatf("vec%0d.sel", i), bus.mem_addr_sel, vecs[i].sel);
      check($sformatf("vec%0d.en", i), bus.mem_en, vecs[i].en);
      check($sformatf("vec%0d.addr", i), bus.mem_addr, vecs[i].addr);
      check($sformatf("vec%0d.done", i), bus.pipe_done, vecs[i].done);
      check($sformatf("vec%0d.stall", i), bus.pipe_stall, vecs[i].stall);
      check($sformatf("vec%0d.gnt", i), bus.fill_gnt, vecs[i].gnt);
      @(posedge clk) #1;
    end

`ifdef DMEM_MISS_PERF_EN
    check("perf.after_table", miss_count, 2);
    miss_clr = 1'b1;
    @(posedge clk) #1;
    check("perf.clr", miss_count, 0);
`endif

    // Reset asserted mid-cycle during the second MISS cycle; clear held over the miss.
    drive(1, 0, 0, 32'h40, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
`ifdef DMEM_MISS_PERF_EN
    check("perf.clr_prio", miss_count, 0);
    miss_clr = 1'b0;
`endif
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    bus.mem_hit = 1'b1;
    #1;
    check("rstmiss.en", bus.mem_en, 0);
    check("rstmiss.sel", bus.mem_addr_sel, 0);
    check("rstmiss.done", bus.pipe_done, 0);
    check("rstmiss.stall", bus.pipe_stall, 1);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("rstmiss.regrant_en", bus.mem_en, 1);
    check("rstmiss.regrant_done", bus.pipe_done, 1);

    // Reset asserted while a fill owns the port.
    @(posedge clk) #1;
    drive(0, 1, 0, 32'h40, 32'h300);
    @(posedge clk) #3;
    check("rstfill.pre_sel", bus.mem_addr_sel, 1);
    rst_n = 1'b0;
    #1;
    check("rstfill.sel", bus.mem_addr_sel, 0);
    check("rstfill.en", bus.mem_en, 0);
    check("rstfill.gnt", bus.fill_gnt, 0);
    check("rstfill.addr", bus.mem_addr, 32'h40);

    // Random traffic against the model.
    drive(0, 0, 0, 32'h0, 32'h0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    prev_done = 1'b0;
    pr = 1'b0;
    pa = 32'h0;
    @(posedge clk) #1;
    for (int c = 0; c < 3000; c++) begin
      if (pr && !prev_done) pr = ($urandom_range(0, 19) != 0);
      else begin
        pr = 1'($urandom_range(0, 1));
        pa = $urandom & 32'hFFFF_FFFC;
      end
      fr  = ($urandom_range(0, 9) < 6);
      hit = 1'($urandom_range(0, 1));
      fa  = $urandom & 32'hFFFF_FFFC;
      clr = ($urandom_range(0, 49) == 0);
      drive(pr, fr, hit, pa, fa);
`ifdef DMEM_MISS_PERF_EN
      miss_clr = clr;
`endif
      @(negedge clk);
      e_done = (m_owner == OwnPipe) && pr && hit;
      check("rnd.sel", bus.mem_addr_sel, m_owner == OwnFill);
      check("rnd.en", bus.mem_en, m_owner != OwnNone);
      check("rnd.addr", bus.mem_addr, (m_owner == OwnFill) ? fa : pa);
      check("rnd.done", bus.pipe_done, e_done);
      check("rnd.stall", bus.pipe_stall, pr && !e_done);
      check("rnd.gnt", bus.fill_gnt, m_owner == OwnFill);
`ifdef DMEM_MISS_PERF_EN
      check("rnd.miss_count", miss_count, m_misses);
`endif
      prev_done = e_done;
      model_step(pr, fr, hit, clr);
      @(posedge clk) #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences the single data-memory port in the MEM stage between two requesters: the pipeline load slot (port P) and the fill/loader engine (port F).
- Drives the MEM-stage address-select (0 = pipeline, 1 = fill) and the selected address.
- Handles dataMem misses with a fixed-latency wait-and-retry; raises stall back to the pipeline.
- Bounds fill starvation with a counter.

Parameters:
MISS_LAT, 4, cycles spent in MISS before a pipeline retry (>=1)
STARVE_MAX, 3, consecutive P grants with F pending before F is forced to win (>=1)
CNT_W, 3, width of miss-latency and starvation counters (must hold max(MISS_LAT,STARVE_MAX))

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
pipe_req  in  1  pipeline needs a memory access this cycle (held until done)
pipe_addr  in  32  pipeline address (p3 mem address)
fill_req  in  1  fill engine requests an access
fill_addr  in  32  fill engine address
mem_hit  in  1  hit from dataMem for the access presented this cycle
mem_addr_sel  out  1  address-mux select: 0 pipeline, 1 fill
mem_addr  out  32  selected address to dataMem
mem_en  out  1  memory access valid this cycle
pipe_done  out  1  one-cycle pulse: pipeline access hit and completed
pipe_stall  out  1  freeze pipeline registers upstream of MEM
fill_gnt  out  1  one-cycle pulse: fill access performed this cycle

Behaviour:
- States: ARB, GNT_P, GNT_F, MISS. Reset (reset==0, asynchronous) -> ARB, counters 0, all registered outputs 0; mem_addr_sel=0.
- mem_addr = mem_addr_sel ? fill_addr : pipe_addr (combinational). mem_addr_sel=1 only in GNT_F.
- mem_en=1 in GNT_P and GNT_F; 0 in ARB and MISS.
- ARB:
  - pipe_req only -> GNT_P.
  - fill_req only -> GNT_F.
  - Both, starve_cnt < STARVE_MAX -> GNT_P, starve_cnt++.
  - Both, starve_cnt == STARVE_MAX -> GNT_F.
  - Neither -> stay.
- GNT_P:
  - mem_hit=1 -> pipe_done=1, -> ARB.
  - mem_hit=0 -> MISS, miss_cnt <= MISS_LAT-1.
  - pipe_req=0 (flush) -> ARB, no pipe_done.
- MISS:
  - miss_cnt decrements each cycle; at 0 -> GNT_P (retry, same pipe_addr).
  - pipe_req drops -> ARB immediately (abort).
  - A fill request is not served in MISS.
- GNT_F:
  - fill_gnt=1, starve_cnt <= 0.
  - Next state: fill_req && !pipe_req -> GNT_F (back-to-back); otherwise -> ARB.
- Stall: pipe_stall = pipe_req && !pipe_done (combinational). Pipeline latency: best case 2 cycles req->done (ARB, GNT_P). Miss adds MISS_LAT+1 cycles per miss.
- starve_cnt increments only on a P grant with fill_req high; it saturates at STARVE_MAX.
- Repeated misses retry indefinitely; no timeout.

Optional Feature:
- Macro: DMEM_MISS_PERF_EN.
- Enabled:
  - Adds output miss_count [15:0], a saturating count of GNT_P cycles with mem_hit=0. It holds at 16'hFFFF.
  - Adds input miss_count_clr (1 bit): synchronous clear, which has priority over increment.
  - Async reset clears the count to 0.
- Disabled: neither port nor counter exists. All other behaviour is identical.

Test Plan:
- Reset mid-MISS: assert reset at cycle 2 of a miss -> state ARB, pipe_done=0, mem_en=0, and mem_addr_sel=0 immediately, without waiting for a clock edge.
- Pipeline hit: pipe_req=1, pipe_addr=0x40, mem_hit=1 -> cycle 1 mem_en=1, mem_addr=0x40, sel=0, pipe_done=1; pipe_stall high only in the ARB cycle.
- Miss/retry (MISS_LAT=4): mem_hit=0 on first GNT_P, 1 on retry -> mem_en low 4 cycles, retry at 0x40, pipe_done on cycle 6.
- Fill back-to-back: fill_req=1 for 3 cycles, fill_addr=0x100/0x104/0x108, pipe_req=0 -> fill_gnt on 3 consecutive cycles with sel=1 and the matching addresses.
- Starvation (STARVE_MAX=3): pipe_req and fill_req held high, every P access hits -> P,P,P,F,P,P,P,F grant pattern.
- Flush during MISS: drop pipe_req at MISS cycle 1 -> ARB next cycle, no retry, no pipe_done. With DMEM_MISS_PERF_EN, miss_count=1.
